// File: rtl/saboteur_pkg.sv
// saboteur_pkg: fault-mode encodings and injection counter width shared by the saboteur cells.
package saboteur_pkg;
  localparam logic [1:0] FM_SA0  = 2'b00;
  localparam logic [1:0] FM_SA1  = 2'b01;
  localparam logic [1:0] FM_FLIP = 2'b10;
  localparam logic [1:0] FM_HOLD = 2'b11;
  localparam int CNT_W = 16;
endpackage

// File: rtl/basic_saboteur.sv
// basic_saboteur: single-bit fault cell with its own hold flop and fault-mode mux.
module basic_saboteur
  import saboteur_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sig,
  input  logic       i_en,
  input  logic [1:0] i_ctrl,
  output logic       o_sig
);
  logic hold_q, hold_d, frz;
  assign frz = i_en && (i_ctrl == FM_HOLD);
  always_comb begin
    hold_d = frz ? hold_q : i_sig;
    o_sig  = !i_en ? i_sig :
             i_ctrl == FM_SA0  ? 1'b0 :
             i_ctrl == FM_SA1  ? 1'b1 :
             i_ctrl == FM_FLIP ? ~i_sig : hold_q;
  end
  always_ff @(posedge i_clk)
    hold_q <= i_rst ? 1'b0 : hold_d;
endmodule

// File: rtl/super_saboteur.sv
// super_saboteur: WIDTH-bit in-line fault injector; SABOTEUR_INJ_COUNT_EN adds an injection-cycle counter.
module super_saboteur
  import saboteur_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sig,
  input  logic             i_en_super_sabouter,
  input  logic [WIDTH-1:0] i_en_basic_sabouter,
  input  logic [1:0]       i_ctrl,
`ifdef SABOTEUR_INJ_COUNT_EN
  output logic [CNT_W-1:0] o_inj_cnt,
  output logic             o_inj_active,
`endif
  output logic [WIDTH-1:0] o_sig
);
  logic [WIDTH-1:0] en;
  assign en = {WIDTH{i_en_super_sabouter}} & i_en_basic_sabouter;
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    basic_saboteur u_bit (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_sig  (i_sig[g]),
      .i_en   (en[g]),
      .i_ctrl (i_ctrl),
      .o_sig  (o_sig[g])
    );
  end
`ifdef SABOTEUR_INJ_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // saturates rather than wrapping so long campaigns never under-report
  always_comb
    cnt_d = (|en && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge i_clk)
    cnt_q <= i_rst ? '0 : cnt_d;
  assign o_inj_cnt    = cnt_q;
  assign o_inj_active = |en;
`endif
endmodule

// File: tb/tb_super_saboteur.sv
// tb_super_saboteur: directed test-plan cases plus randomized traffic against a behavioural model.
module tb_super_saboteur;
  logic       clk = 0;
  logic       rst = 1;
  logic [2:0] sig = 0;
  logic       sup = 0;
  logic [2:0] msk = 0;
  logic [1:0] ctl = 0;
  logic [2:0] osig;
  int errs = 0;
  int chks = 0;
  logic [2:0] m_hold = 0;
  int m_cnt = 0;
`ifdef SABOTEUR_INJ_COUNT_EN
  logic [15:0] cnt;
  logic        act;
`endif
  always #5 clk = ~clk;
  super_saboteur #(.WIDTH(3)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_sig               (sig),
    .i_en_super_sabouter (sup),
    .i_en_basic_sabouter (msk),
    .i_ctrl              (ctl),
`ifdef SABOTEUR_INJ_COUNT_EN
    .o_inj_cnt           (cnt),
    .o_inj_active        (act),
`endif
    .o_sig               (osig)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] model_out();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) begin
      if (!(sup && msk[i])) r[i] = sig[i];
      else case (ctl)
        2'd0: r[i] = 1'b0;
        2'd1: r[i] = 1'b1;
        2'd2: r[i] = ~sig[i];
        default: r[i] = m_hold[i];
      endcase
    end
    return r;
  endfunction
  task automatic tick();
    #1;
    chk("o_sig", 32'(osig), 32'(model_out()));
`ifdef SABOTEUR_INJ_COUNT_EN
    chk("inj_active", 32'(act), 32'(sup && (msk != 0)));
    chk("inj_cnt", 32'(cnt), 32'(m_cnt));
`endif
    @(posedge clk);
    if (rst) begin
      m_hold = 0;
      m_cnt = 0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (!(sup && msk[i] && ctl == 2'd3)) m_hold[i] = sig[i];
      if (sup && msk != 0 && m_cnt < 65535) m_cnt++;
    end
    @(negedge clk);
  endtask
  task automatic drive(input logic r, input logic [2:0] s, input logic su, input logic [2:0] m, input logic [1:0] c);
    rst = r; sig = s; sup = su; msk = m; ctl = c;
    #1;
  endtask
  initial begin
    @(posedge clk);
    @(negedge clk);
    drive(0, 3'b101, 0, 3'b000, 2'b00); chk("idle", 32'(osig), 32'h5); tick();
    drive(0, 3'b101, 0, 3'b111, 2'b11); chk("global_dom", 32'(osig), 32'h5); tick();
    drive(0, 3'b101, 1, 3'b011, 2'b00); chk("sa0", 32'(osig), 32'h4); tick();
    drive(0, 3'b101, 1, 3'b011, 2'b01); chk("sa1", 32'(osig), 32'h7); tick();
    drive(0, 3'b101, 1, 3'b111, 2'b10); chk("flip_a", 32'(osig), 32'h2); tick();
    drive(0, 3'b110, 1, 3'b111, 2'b10); chk("flip_b", 32'(osig), 32'h1); tick();
    drive(0, 3'b101, 0, 3'b111, 2'b11); tick();
    drive(0, 3'b010, 1, 3'b111, 2'b11); chk("freeze", 32'(osig), 32'h5); tick();
    chk("freeze_held", 32'(osig), 32'h5); tick();
    drive(0, 3'b010, 0, 3'b111, 2'b11); chk("release", 32'(osig), 32'h2); tick();
    drive(0, 3'b111, 1, 3'b111, 2'b11); tick();
    drive(1, 3'b111, 1, 3'b111, 2'b11); tick();
    drive(0, 3'b111, 1, 3'b111, 2'b11); chk("rst_freeze", 32'(osig), 32'h0); tick();
`ifdef SABOTEUR_INJ_COUNT_EN
    drive(1, 3'b000, 0, 3'b000, 2'b00); tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 3'(k), 1, 3'b001, 2'b01);
      chk("active_on", 32'(act), 32'h1);
      tick();
    end
    drive(0, 3'b000, 0, 3'b111, 2'b00);
    chk("cnt5", 32'(cnt), 32'h5);
    chk("active_off", 32'(act), 32'h0);
    tick();
`endif
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 29) == 0, 3'($urandom), $urandom_range(0, 3) != 0,
            3'($urandom), 2'($urandom));
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
